nw_job_scheduler: RTL and testbench
===================================

Name: nw_job_scheduler

Overview:
- Front-end controller for the Needleman-Wunsch Grid.
- Arbitrates round-robin between NREQ requesters, each submitting a string pair.
- For the granted pair it latches the strings, drives them onto the grid, pulses grid_start, and waits for grid_valid or a timeout.
- Returns the score plus the requester ID on a valid/ready result port. Only one job is in flight at a time.

Parameters:
- LENGTH, 10, characters per string.
- CWIDTH, 2, bits per character.
- SWIDTH, 16, bits per signed score.
- NREQ, 2, number of requesters (2..8).
- IDW, 1, width of the requester ID; must satisfy 2**IDW >= NREQ.
- TWIDTH, 12, width of the timeout counter.
- TIMEOUT, 4000, maximum cycles spent in WAIT before the job is aborted; must be less than 2**TWIDTH.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  NREQ  per-requester job request.
- req_ready  out  NREQ  per-requester accept; one-hot or zero.
- req_s1  in  NREQ*LENGTH*CWIDTH  packed string 1 per requester; slice i is [i*LENGTH*CWIDTH +: LENGTH*CWIDTH].
- req_s2  in  NREQ*LENGTH*CWIDTH  packed string 2 per requester, same slicing as req_s1.
- grid_s1  out  LENGTH*CWIDTH  string 1 driven to the grid.
- grid_s2  out  LENGTH*CWIDTH  string 2 driven to the grid.
- grid_start  out  1  one-cycle start pulse to the grid.
- grid_valid  in  1  grid completion flag.
- grid_score  in  SWIDTH  signed final score from the grid.
- res_valid  out  1  result available.
- res_ready  in  1  result consumer accept.
- res_score  out  SWIDTH  signed score; 0 on timeout.
- res_id  out  IDW  index of the requester that owns the result.
- res_timeout  out  1  result was produced by a timeout, not by the grid.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; rr_ptr=0.
  - Outputs cleared: grid_s1, grid_s2, grid_start, res_valid, res_score, res_id, res_timeout, timer all 0.
  - req_ready=0 while reset is asserted.
  - Reset asserted mid-job abandons the job with no result; the requester must resubmit.
- States: IDLE -> START -> WAIT -> DONE -> IDLE.
- IDLE:
  - req_ready is combinational. It is one-hot on the first requester with req_valid=1, scanning from rr_ptr upward and wrapping modulo NREQ.
  - The handshake completes in the same cycle (valid & ready). On that edge the controller:
    - latches the requester's slices into grid_s1/grid_s2;
    - latches the index into a job-ID register;
    - sets rr_ptr = granted+1, wrapping to 0 after NREQ-1;
    - moves to START.
  - With no req_valid asserted, stays in IDLE.
- START:
  - grid_start=1 for exactly this cycle.
  - Clears timer to 0, then moves to WAIT.
  - req_ready=0 in every state other than IDLE.
- WAIT:
  - grid_s1/grid_s2 are held stable.
  - grid_valid is sampled only in WAIT; a grid_valid seen in IDLE or START is ignored.
  - If grid_valid=1: res_score<=grid_score, res_timeout<=0, move to DONE.
  - Otherwise, if timer==TIMEOUT-1: res_score<=0, res_timeout<=1, move to DONE.
  - Otherwise timer increments. The timer saturates and never wraps.
  - If grid_valid and the timeout condition occur in the same cycle, grid_valid wins and res_timeout=0.
- DONE:
  - res_valid=1. res_score, res_id and res_timeout are held stable until res_valid & res_ready.
  - On that handshake: res_valid<=0 and the state moves to IDLE.
  - No new grant occurs in the handshake cycle itself; the earliest next grant is one cycle later.
- Latency:
  - Request accepted at edge T; grid_start is high in cycle T+1.
  - grid_valid sampled at edge W gives res_valid high from cycle W+1.
  - The minimum job-to-job spacing is 4 cycles plus the grid run time.
- Score is passed through unmodified and signed; no arithmetic is done on it.
- grid_s1/grid_s2 keep the last job's strings until the next grant.

Test Plan:
- Single job: reset, then req_valid[0]=1 with s1=s2=0x00000 (all A) and grid model asserting grid_valid 30 cycles after start with score 10 -> one grid_start pulse, then res_valid with res_score=10, res_id=0, res_timeout=0, busy high throughout.
- Fairness: req_valid=2'b11 held continuously for 4 jobs -> grant order 0,1,0,1 and res_id sequence 0,1,0,1.
- Timeout: TIMEOUT=16 and grid_valid never asserted -> res_valid exactly 16 cycles after WAIT entry with res_score=0 and res_timeout=1.
- Tie: grid_valid asserted in the same cycle timer reaches TIMEOUT-1 -> res_timeout=0 and res_score=grid_score.
- Backpressure: res_ready=0 for 20 cycles -> res_* stable, req_ready=0 for requester 1 even with req_valid high; res_ready=1 -> next grant one cycle later.
- Reset mid-WAIT: reset low for 1 cycle -> busy=0, res_valid=0, no result emitted, rr_ptr=0 so requester 0 wins the next simultaneous request.

Source files
------------

// File: rtl/nw_job_scheduler.sv
// nw_job_scheduler: round-robin front end for the Needleman-Wunsch grid.
// Grants one requester at a time, hands its string pair to the grid, waits
// for completion or a timeout, and returns the score and owner ID on a
// valid/ready result port. Only one job is in flight at any time.
module nw_job_scheduler #(
    parameter int LENGTH  = 10,
    parameter int CWIDTH  = 2,
    parameter int SWIDTH  = 16,
    parameter int NREQ    = 2,
    parameter int IDW     = 1,
    parameter int TWIDTH  = 12,
    parameter int TIMEOUT = 4000
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [NREQ-1:0]                 req_valid,
    output logic [NREQ-1:0]                 req_ready,
    input  logic [NREQ*LENGTH*CWIDTH-1:0]   req_s1,
    input  logic [NREQ*LENGTH*CWIDTH-1:0]   req_s2,
    output logic [LENGTH*CWIDTH-1:0]        grid_s1,
    output logic [LENGTH*CWIDTH-1:0]        grid_s2,
    output logic                            grid_start,
    input  logic                            grid_valid,
    input  logic signed [SWIDTH-1:0]        grid_score,
    output logic                            res_valid,
    input  logic                            res_ready,
    output logic signed [SWIDTH-1:0]        res_score,
    output logic [IDW-1:0]                  res_id,
    output logic                            res_timeout,
    output logic                            busy
);

    localparam int SLW = LENGTH * CWIDTH;
    localparam logic [TWIDTH-1:0] TIMER_LAST = TWIDTH'(TIMEOUT - 1);
    localparam logic [TWIDTH-1:0] TIMER_MAX  = {TWIDTH{1'b1}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_WAIT,
        S_DONE
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [IDW-1:0]    rr_ptr;
    logic [IDW-1:0]    grant_idx;
    logic              grant_found;
    logic [TWIDTH-1:0] timer;

    // Requester index base+k, wrapped modulo NREQ (NREQ need not be a power of two).
    function automatic logic [IDW-1:0] wrap_idx(input logic [IDW-1:0] base, input int k);
        int s;
        s = int'(base) + k;
        if (s >= NREQ) s = s - NREQ;
        return IDW'(s);
    endfunction

    // Round-robin scan: first valid requester at or after rr_ptr.
    always_comb begin
        // NOTE: every variable written here gets a default first so no latch is inferred.
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!grant_found && req_valid[wrap_idx(rr_ptr, k)]) begin
                grant_found = 1'b1;
                grant_idx   = wrap_idx(rr_ptr, k);
            end
        end
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (!reset) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic; a grid_valid outside WAIT has no effect.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (grant_found) state_nxt = S_START;
            S_START: state_nxt = S_WAIT;
            S_WAIT:  if (grid_valid || timer == TIMER_LAST) state_nxt = S_DONE;
            S_DONE:  if (res_ready) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Moore outputs plus the combinational grant; no grant while reset is held.
    always_comb begin
        req_ready  = '0;
        if (state == S_IDLE && grant_found && reset) req_ready[grant_idx] = 1'b1;
        grid_start = (state == S_START);
        res_valid  = (state == S_DONE);
        busy       = (state != S_IDLE);
    end

    // Job datapath: latch strings and owner on grant, run the timer, capture the result.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            grid_s1     <= '0;
            grid_s2     <= '0;
            res_id      <= '0;
            rr_ptr      <= '0;
            timer       <= '0;
            res_score   <= '0;
            res_timeout <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (grant_found) begin
                        grid_s1 <= req_s1[grant_idx*SLW +: SLW];
                        grid_s2 <= req_s2[grant_idx*SLW +: SLW];
                        res_id  <= grant_idx;
                        rr_ptr  <= wrap_idx(grant_idx, 1);
                    end
                end
                S_START: timer <= '0;
                S_WAIT: begin
                    // grid_valid takes priority over an expiring timer.
                    if (grid_valid) begin
                        res_score   <= grid_score;
                        res_timeout <= 1'b0;
                    end else if (timer == TIMER_LAST) begin
                        res_score   <= '0;
                        res_timeout <= 1'b1;
                    end else if (timer != TIMER_MAX) begin
                        timer <= timer + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_nw_job_scheduler.sv
// tb_nw_job_scheduler: directed and randomized jobs against a transaction-level
// model of arbitration order, result latency, score and timeout flag.
module tb_nw_job_scheduler;

    localparam int LENGTH = 10;
    localparam int CWIDTH = 2;
    localparam int SWIDTH = 16;
    localparam int NREQ   = 3;
    localparam int IDW    = 2;
    localparam int TWIDTH = 12;
    localparam int TO     = 32;
    localparam int SLW    = LENGTH * CWIDTH;
    localparam int SALL   = NREQ * SLW;

    logic                     clk;
    logic                     reset;
    logic [NREQ-1:0]          req_valid;
    logic [NREQ-1:0]          req_ready;
    logic [SALL-1:0]          req_s1;
    logic [SALL-1:0]          req_s2;
    logic [SLW-1:0]           grid_s1;
    logic [SLW-1:0]           grid_s2;
    logic                     grid_start;
    logic                     grid_valid;
    logic signed [SWIDTH-1:0] grid_score;
    logic                     res_valid;
    logic                     res_ready;
    logic signed [SWIDTH-1:0] res_score;
    logic [IDW-1:0]           res_id;
    logic                     res_timeout;
    logic                     busy;

    int n_cmp = 0;
    int n_bad = 0;
    int mdl_rr = 0;
    int grid_delay = -1;
    logic signed [SWIDTH-1:0] grid_score_val = '0;

    nw_job_scheduler #(
        .LENGTH(LENGTH), .CWIDTH(CWIDTH), .SWIDTH(SWIDTH), .NREQ(NREQ),
        .IDW(IDW), .TWIDTH(TWIDTH), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_s1(req_s1), .req_s2(req_s2),
        .grid_s1(grid_s1), .grid_s2(grid_s2), .grid_start(grid_start),
        .grid_valid(grid_valid), .grid_score(grid_score),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_score(res_score), .res_id(res_id), .res_timeout(res_timeout),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Grid model: grid_valid for one cycle, grid_delay cycles after the start pulse (-1 = never).
    initial begin
        int cd;
        logic gv;
        cd = -1;
        grid_valid = 1'b0;
        grid_score = '0;
        forever begin
            @(negedge clk);
            if (grid_start) begin
                cd = grid_delay;
                gv = 1'b0;
            end else if (cd > 0) begin
                cd--;
                gv = (cd == 0);
            end else begin
                gv = 1'b0;
            end
            grid_valid = gv;
            grid_score = gv ? grid_score_val : SWIDTH'($urandom);
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [SALL-1:0] rand_str();
        return SALL'({$urandom, $urandom});
    endfunction

    // Reference arbitration: first valid requester scanning upward from the pointer.
    function automatic int model_grant(input logic [NREQ-1:0] vec);
        for (int k = 0; k < NREQ; k++)
            if (vec[(mdl_rr + k) % NREQ]) return (mdl_rr + k) % NREQ;
        return -1;
    endfunction

    // One complete job: request, start pulse, completion/timeout, optional backpressure, handshake.
    task automatic run_job(input logic [NREQ-1:0] vec, input bit keep, input int d,
                           input logic signed [SWIDTH-1:0] score, input int hold,
                           input logic [SALL-1:0] s1v, input logic [SALL-1:0] s2v);
        int id, lat, n;
        bit extra_start, busy_drop, str_moved;
        logic [SLW-1:0] e1, e2;
        logic signed [SWIDTH-1:0] exp_score;
        logic exp_to;
        logic [NREQ-1:0] exp_ready;

        req_s1 = s1v;
        req_s2 = s2v;
        req_valid = vec;
        grid_delay = d;
        grid_score_val = score;
        #1;
        id = model_grant(vec);
        exp_ready = NREQ'(1) << id;
        check("req_ready_grant", req_ready, exp_ready);
        check("busy_idle", busy, 0);
        mdl_rr = (id + 1) % NREQ;
        e1 = s1v[id*SLW +: SLW];
        e2 = s2v[id*SLW +: SLW];
        if (d >= 1 && d <= TO) begin
            lat = d + 1; exp_score = score; exp_to = 1'b0;
        end else begin
            lat = TO + 1; exp_score = '0; exp_to = 1'b1;
        end

        @(posedge clk); #1;
        if (!keep) req_valid = '0;
        check("grid_start_pulse", grid_start, 1);
        check("busy_start", busy, 1);
        check("req_ready_busy", req_ready, 0);
        check("grid_s1", grid_s1, e1);
        check("grid_s2", grid_s2, e2);

        n = 0; extra_start = 0; busy_drop = 0; str_moved = 0;
        while (!res_valid && n < 4 * TO) begin
            @(posedge clk); #1;
            n++;
            if (grid_start) extra_start = 1;
            if (!busy) busy_drop = 1;
            if (grid_s1 !== e1 || grid_s2 !== e2) str_moved = 1;
        end
        check("result_latency", n, lat);
        check("single_start", extra_start, 0);
        check("busy_held", busy_drop, 0);
        check("strings_held", str_moved, 0);
        check("res_score", res_score, exp_score);
        check("res_id", res_id, id);
        check("res_timeout", res_timeout, exp_to);

        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check("hold_valid", res_valid, 1);
            check("hold_score", res_score, exp_score);
            check("hold_id", res_id, id);
            check("hold_timeout", res_timeout, exp_to);
            check("hold_no_grant", req_ready, 0);
        end

        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        check("res_valid_cleared", res_valid, 0);
        check("busy_idle_after", busy, 0);
    endtask

    initial begin
        bit leak;
        reset = 1'b0;
        req_valid = '1;
        res_ready = 1'b0;
        req_s1 = rand_str();
        req_s2 = rand_str();
        repeat (3) @(negedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_res_valid", res_valid, 0);
        check("rst_req_ready", req_ready, 0);
        check("rst_grid_start", grid_start, 0);
        check("rst_grid_s1", grid_s1, 0);
        check("rst_grid_s2", grid_s2, 0);
        check("rst_res_score", res_score, 0);
        check("rst_res_id", res_id, 0);
        check("rst_res_timeout", res_timeout, 0);
        req_valid = '0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        // Fairness: two requesters held valid, expected order 0,1,0,1.
        for (int j = 0; j < 4; j++) begin
            check("fair_order", model_grant(3'b011), j % 2);
            run_job(3'b011, 1'b1, 5 + j, SWIDTH'($urandom), 0, rand_str(), rand_str());
        end
        req_valid = '0;

        // Single job, all-A strings, grid answers 30 cycles after start with score 10.
        run_job(3'b001, 1'b0, 30, 16'sd10, 0, '0, '0);

        // Timeout: grid never answers.
        run_job(3'b001, 1'b0, -1, 16'sd77, 0, rand_str(), rand_str());

        // Tie: grid_valid in the last WAIT cycle wins over the timeout.
        run_job(3'b010, 1'b0, TO, -16'sd1234, 0, rand_str(), rand_str());

        // Backpressure with requester 1 still requesting, then the follow-up grant.
        run_job(3'b011, 1'b1, 10, 16'sd300, 20, rand_str(), rand_str());
        run_job(3'b011, 1'b0, 7, -16'sd5, 0, rand_str(), rand_str());

        // Reset mid-WAIT: job on requester 1 abandoned, pointer returns to 0.
        req_s1 = rand_str();
        req_s2 = rand_str();
        grid_delay = -1;
        req_valid = 3'b010;
        @(posedge clk); #1;
        req_valid = '1;
        repeat (6) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_res_valid", res_valid, 0);
        check("midrst_req_ready", req_ready, 0);
        check("midrst_grid_s1", grid_s1, 0);
        @(negedge clk);
        reset = 1'b1;
        req_valid = '0;
        mdl_rr = 0;
        leak = 0;
        repeat (TO + 6) begin
            @(posedge clk); #1;
            if (res_valid || busy) leak = 1;
        end
        check("midrst_no_result", leak, 0);
        check("midrst_rr_zero", model_grant(3'b111), 0);
        run_job(3'b111, 1'b0, 12, 16'sd42, 0, rand_str(), rand_str());

        // Randomized jobs, including late grid_valid landing in DONE or IDLE.
        for (int j = 0; j < 14; j++) begin
            logic [NREQ-1:0] vec;
            int d;
            vec = NREQ'($urandom_range(1, (1 << NREQ) - 1));
            d = ($urandom_range(0, 5) == 0) ? -1 : int'($urandom_range(1, TO + 2));
            run_job(vec, 1'($urandom), d, SWIDTH'($urandom), $urandom_range(0, 3),
                    rand_str(), rand_str());
            req_valid = '0;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
